// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the main-memory responder.
// Bounds checking is enabled with CACHE_MEM_BOUNDS_CHECK_EN.
package cache_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = 5;
  localparam int BEAT_W     = 3;
  localparam int LINE_W     = WORD_W - OFFSET_W;

  typedef logic [2:0] rsp_state_t;

  localparam rsp_state_t ST_IDLE   = 3'd0;
  localparam rsp_state_t ST_WAIT   = 3'd1;
  localparam rsp_state_t ST_RBURST = 3'd2;
  localparam rsp_state_t ST_WBURST = 3'd3;
  localparam rsp_state_t ST_RESP   = 3'd4;

  typedef logic [LINE_W-1:0] line_idx_t;
  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(LINE_WORDS - 1);

  function automatic line_idx_t line_of(
    input logic [WORD_W-1:0] addr
  );
    return addr[WORD_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Backing word RAM: one synchronous write port,
// one registered read port (old data on collision).
module mem_word_ram
  import cache_mem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache miss path: one line per request.
// Optional out-of-range detection under CACHE_MEM_BOUNDS_CHECK_EN.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_LINES = 256
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        rlast,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic        done,
  output logic        err
);

  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int AW     = IDX_W + BEAT_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

  rsp_state_t       state;
  logic             we_q;
  line_idx_t        line_q;
  beat_t            beat;
  logic [CNT_W-1:0] cnt;
  logic             oor_q;

  line_idx_t        req_line;
  logic             oor_req;
  line_idx_t        rd_line;
  beat_t            rd_beat;
  logic             ram_we;
  logic [WORD_W-1:0] ram_q;

  assign req_line = line_of(req_addr);

`ifdef CACHE_MEM_BOUNDS_CHECK_EN
  assign oor_req = req_line >= line_idx_t'(MEM_LINES);
`else
  assign oor_req = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= ST_IDLE;
      we_q   <= 1'b0;
      line_q <= '0;
      beat   <= '0;
      cnt    <= '0;
      oor_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            line_q <= req_line;
            oor_q  <= oor_req;
            beat   <= '0;
            cnt    <= CNT_W'(LAT_M1);
            if (LATENCY > 0)
              state <= ST_WAIT;
            else
              state <= req_we ? ST_WBURST : ST_RBURST;
          end
        end
        ST_WAIT: begin
          if (cnt == '0)
            state <= we_q ? ST_WBURST : ST_RBURST;
          else
            cnt <= cnt - 1'b1;
        end
        ST_RBURST: begin
          beat <= beat + 1'b1;
          if (beat == LAST_BEAT) state <= ST_RESP;
        end
        ST_WBURST: begin
          if (wvalid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read address runs one beat ahead so RAM output lines up with rvalid.
  assign rd_line = (state == ST_IDLE) ? req_line : line_q;
  assign rd_beat = (state == ST_RBURST) ? beat_t'(beat + 1'b1) : '0;
  assign ram_we  = (state == ST_WBURST) && wvalid && !oor_q;

  mem_word_ram #(
    .DEPTH (MEM_LINES * LINE_WORDS),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr ({line_q[IDX_W-1:0], beat}),
    .wdata (wdata),
    .raddr ({rd_line[IDX_W-1:0], rd_beat}),
    .rdata (ram_q)
  );

  assign req_ready = (state == ST_IDLE);
  assign rvalid    = (state == ST_RBURST);
  assign rlast     = rvalid && (beat == LAST_BEAT);
  assign wready    = (state == ST_WBURST);
  assign done      = (state == ST_RESP);
  assign rdata     = (rvalid && !oor_q) ? ram_q : '0;

`ifdef CACHE_MEM_BOUNDS_CHECK_EN
  assign err = done && oor_q;
`else
  assign err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{req_addr[OFFSET_W-1:0],
                         line_q[LINE_W-1:IDX_W],
                         rd_line[LINE_W-1:IDX_W]};

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized scoreboard bench for cache_mem_responder,
// with a second LATENCY=0 instance for the zero-latency path.
module tb_cache_mem_responder;

  localparam int LAT = 4;
  localparam int NL  = 256;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, rdata, wdata;
  logic        rvalid, rlast, wvalid, wready, done, err;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_rdata, z_wdata;
  logic        z_rvalid, z_rlast, z_wvalid, z_wready, z_done, z_err;

  cache_mem_responder #(.LATENCY(LAT), .MEM_LINES(NL)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .done(done), .err(err)
  );

  cache_mem_responder #(.LATENCY(0), .MEM_LINES(NL)) dut0 (
    .CLK(CLK), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr),
    .rdata(z_rdata), .rvalid(z_rvalid), .rlast(z_rlast),
    .wdata(z_wdata), .wvalid(z_wvalid), .wready(z_wready),
    .done(z_done), .err(z_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic [31:0] model [NL*8];
  logic [31:0] wbuf [8];
  logic [31:0] zbuf [8];
  exp_t        rd_q[$];
  logic        err_q[$];
  logic [31:0] z_q[$];
  int          first_rv;
  int          beat_seen;
  int          z_first;
  int          z_dones;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
`ifdef CACHE_MEM_BOUNDS_CHECK_EN
    return (a >> 5) >= NL;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a, input int b);
    int unsigned l;
    l = int'((a >> 5) % NL);
    return int'(l) * 8 + b;
  endfunction

  // Scoreboard monitor for the main instance.
  always @(negedge CLK) begin
    exp_t e;
    logic ee;
    if (!reset) begin
      if (rvalid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got rvalid=1 expected no beat");
        end else begin
          e = rd_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rlast", 32'(rlast), 32'(e.last));
        end
        if (beat_seen == 0) first_rv = cyc;
        beat_seen++;
      end
      if (done) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          ee = err_q.pop_front();
          chk("err", 32'(err), 32'(ee));
        end
      end
    end
  end

  // Scoreboard monitor for the zero-latency instance.
  always @(negedge CLK) begin
    if (!reset) begin
      if (z_rvalid) begin
        if (z_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL z_rd_unexpected: got rvalid=1 expected no beat");
        end else begin
          chk("z_rdata", z_rdata, z_q.pop_front());
        end
        if (z_first < 0) z_first = cyc;
      end
      if (z_done) z_dones++;
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) ok = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    bit ok;
    int t, n;
    exp_t e;
    wait_ready(ok);
    chk("rd_ready_wait", 32'(ok), 32'd1);
    for (int b = 0; b < 8; b++) begin
      e.data = oor(a) ? 32'h0 : model[widx(a, b)];
      e.last = (b == 7);
      rd_q.push_back(e);
    end
    err_q.push_back(oor(a));
    beat_seen = 0;
    first_rv = -1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF;
    t = cyc;
    @(negedge CLK);
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_done_cycle", 32'(cyc), 32'(t + LAT + 9));
    chk("rd_first_beat", 32'(first_rv), 32'(t + LAT + 1));
    wvalid = 1'b0;
    @(negedge CLK);
    chk("rd_ready_after", 32'(req_ready), 32'd1);
    chk("rd_beats_left", 32'(rd_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input int gap_at,
                          input int gap_len);
    bit ok;
    int t, n, b;
    wait_ready(ok);
    chk("wr_ready_wait", 32'(ok), 32'd1);
    for (int i = 0; i < 8; i++)
      if (!oor(a)) model[widx(a, i)] = wbuf[i];
    err_q.push_back(oor(a));
    req_valid = 1'b1; req_we = 1'b1; req_addr = a;
    t = cyc;
    @(negedge CLK);
    req_valid = 1'b0;
    b = 0;
    n = 0;
    while (b < 8 && n < 200) begin
      wvalid = 1'b1;
      wdata = wbuf[b];
      if (wready) begin
        @(negedge CLK);
        b++;
        if (gap_len > 0 && b == gap_at + 1) begin
          wvalid = 1'b0;
          repeat (gap_len) begin
            chk("wr_gap_ready", 32'(wready), 32'd1);
            @(negedge CLK);
          end
        end
      end else begin
        @(negedge CLK);
        n++;
      end
    end
    wvalid = 1'b0;
    chk("wr_beats", 32'(b), 32'd8);
    chk("wr_ready_drop", 32'(wready), 32'd0);
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_done_cycle", 32'(cyc), 32'(t + LAT + 9 + gap_len));
    @(negedge CLK);
  endtask

  task automatic reset_mid_read(input logic [31:0] a);
    int t, n, dn;
    exp_t e;
    for (int b = 0; b < 8; b++) begin
      e.data = model[widx(a, b)];
      e.last = (b == 7);
      rd_q.push_back(e);
    end
    err_q.push_back(1'b0);
    beat_seen = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    t = cyc;
    @(negedge CLK);
    req_valid = 1'b0;
    n = 0;
    while (cyc != t + LAT + 5 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_beat4_valid", 32'(rvalid), 32'd1);
    reset = 1'b1;
    @(negedge CLK);
    rd_q.delete();
    err_q.delete();
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    dn = 0;
    repeat (15) begin
      @(negedge CLK);
      if (done) dn++;
    end
    chk("rst_no_done", 32'(dn), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, prev;
    int r, t, n, zb;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    wvalid = 1'b0; wdata = '0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0;
    z_wvalid = 1'b0; z_wdata = '0;
    z_first = -1; z_dones = 0;
    first_rv = -1; beat_seen = 0;
    repeat (3) @(negedge CLK);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rlast", 32'(rlast), 32'd0);
    chk("reset_wready", 32'(wready), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_z_ready", 32'(z_req_ready), 32'd1);
    reset = 1'b0;
    @(negedge CLK);

    for (int l = 0; l < NL; l++) begin
      for (int b = 0; b < 8; b++) wbuf[b] = 32'(l * 8 + b);
      do_write(32'(l) << 5, -1, 0);
    end

    do_read(32'h0000_0040);

    for (int b = 0; b < 8; b++) wbuf[b] = 32'hA0 + 32'(b);
    do_write(32'h0000_0020, -1, 0);
    do_read(32'h0000_0020);
    do_read(32'h0000_0000);
    do_read(32'h0000_0040);

    for (int b = 0; b < 8; b++) wbuf[b] = 32'hB0 + 32'(b);
    do_write(32'h0000_0060, 2, 3);
    do_read(32'h0000_0060);

    reset_mid_read(32'h0000_0080);
    do_read(32'h0000_0080);

    do_read(32'h0000_2000);
    for (int b = 0; b < 8; b++) wbuf[b] = 32'hC0 + 32'(b);
    do_write(32'h0000_2020, -1, 0);
    do_read(32'h0000_0020);
    do_read(32'h0000_2020);

    for (int b = 0; b < 8; b++) zbuf[b] = 32'h5000 + 32'(b);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h0000_00A0;
    z_wvalid = 1'b1; z_wdata = zbuf[0];
    zb = 0;
    t = cyc;
    @(negedge CLK);
    z_req_valid = 1'b0;
    n = 0;
    while (zb < 8 && n < 50) begin
      z_wdata = zbuf[zb];
      if (z_wready) zb++;
      @(negedge CLK);
      n++;
    end
    z_wvalid = 1'b0;
    chk("z_wr_done", 32'(z_done), 32'd1);
    chk("z_wr_done_cycle", 32'(cyc), 32'(t + 9));
    @(negedge CLK);
    for (int b = 0; b < 8; b++) z_q.push_back(zbuf[b]);
    z_first = -1;
    z_dones = 0;
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h0000_00A4;
    t = cyc;
    repeat (10) @(negedge CLK);
    z_req_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("z_first_beat", 32'(z_first), 32'(t + 1));
    chk("z_single_accept", 32'(z_dones), 32'd1);
    chk("z_beats_left", 32'(z_q.size()), 32'd0);

    prev = 32'h0000_0040;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)
        a = $urandom;
      else if (r < 20)
        a = (32'($urandom_range(256, 1023)) << 5) | 32'($urandom_range(0, 31));
      else if (r < 40)
        a = prev;
      else
        a = (32'($urandom_range(0, 255)) << 5) | 32'($urandom_range(0, 31));
      prev = a;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 8; b++) wbuf[b] = $urandom;
        do_write(a, $urandom_range(0, 6), $urandom_range(0, 3));
      end else begin
        do_read(a);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
